// File: rtl/hazard_flush_ctrl.sv
// Hazard/flush controller: drives PC/IF-ID write enables and the IF/ID, ID/EX flush mux selectors.
// Optional perf counters (flush_count, stall_count) are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_flush_ctrl #(
    parameter int REG_BITS     = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int STALL_CYCLES = 1,
    parameter int CNT_BITS     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic                id_uses_rs2,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic                ex_mem_read,
    input  logic                branch_taken,
    output logic                pc_write,
    output logic                if_id_write,
    output logic                if_id_flush_sel,
    output logic                id_ex_flush_sel,
    output logic                busy,
    output logic [CNT_BITS-1:0] flush_count,
    output logic [CNT_BITS-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [3:0] STALL_RELOAD = 4'(STALL_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_haz;
    logic       w_flush_evt;
    logic       w_stall_evt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outputs are decoded in the same cycle: the flush muxes sit right behind us.
    always_comb begin
        w_haz = ex_mem_read && (ex_rd != '0) &&
                ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

        pc_write        = 1'b1;
        if_id_write     = 1'b1;
        if_id_flush_sel = 1'b0;
        id_ex_flush_sel = 1'b0;
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_flush_evt     = 1'b0;
        w_stall_evt     = 1'b0;

        if (r_state == FLUSH) begin
            // A flushed slot cannot carry a real branch, so branch_taken is ignored here.
            if_id_flush_sel = 1'b1;
            id_ex_flush_sel = 1'b1;
            w_cnt_nxt       = r_cnt - 4'd1;
            if (r_cnt <= 4'd1) begin
                w_state_nxt = RUN;
                w_cnt_nxt   = 4'd0;
            end
        end else if (branch_taken) begin
            if_id_flush_sel = 1'b1;
            id_ex_flush_sel = 1'b1;
            w_flush_evt     = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                w_state_nxt = FLUSH;
                w_cnt_nxt   = FLUSH_RELOAD;
            end else begin
                w_state_nxt = RUN;
                w_cnt_nxt   = 4'd0;
            end
        end else if (r_state == STALL) begin
            pc_write        = 1'b0;
            if_id_write     = 1'b0;
            id_ex_flush_sel = 1'b1;
            w_cnt_nxt       = r_cnt - 4'd1;
            if (r_cnt <= 4'd1) begin
                w_state_nxt = RUN;
                w_cnt_nxt   = 4'd0;
            end
        end else if (w_haz) begin
            pc_write        = 1'b0;
            if_id_write     = 1'b0;
            id_ex_flush_sel = 1'b1;
            w_stall_evt     = 1'b1;
            if (STALL_CYCLES > 1) begin
                w_state_nxt = STALL;
                w_cnt_nxt   = STALL_RELOAD;
            end
        end
    end

    assign busy = (r_state != RUN);

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_BITS-1:0] r_flush_count;
    logic [CNT_BITS-1:0] r_stall_count;

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flush_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_flush_evt && (r_flush_count != '1))
                r_flush_count <= r_flush_count + 1'b1;
            if (w_stall_evt && (r_stall_count != '1))
                r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign flush_count = r_flush_count;
    assign stall_count = r_stall_count;
`else
    logic w_unused_evt;
    assign w_unused_evt = w_flush_evt | w_stall_evt;
    assign flush_count  = '0;
    assign stall_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Bench for hazard_flush_ctrl: directed table, hand sequences and randomized run against a cycle model.
module tb_hazard_flush_ctrl;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses;
        logic [4:0] rd;
        logic       mr;
        logic       br;
    } in_t;

    // {pc_write, if_id_write, if_id_flush_sel, id_ex_flush_sel, busy}
    typedef logic [4:0] out_t;

    typedef struct {
        in_t  i;
        out_t o;
        int   fc;
        int   sc;
    } vec_t;

    localparam int FA = 2, SA = 1, CA = 16;
    localparam int FB = 3, SB = 3, CB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    in_t  ia, ib;
    logic a_pc, a_ifid, a_ifsel, a_idsel, a_busy;
    logic b_pc, b_ifid, b_ifsel, b_idsel, b_busy;
    logic [CA-1:0] a_fc, a_sc;
    logic [CB-1:0] b_fc, b_sc;
    out_t oa, ob;

    int checks = 0;
    int errors = 0;

    int m_fl[2], m_st[2], m_fc[2], m_sc[2];

    always #5 clk = ~clk;

    hazard_flush_ctrl #(.REG_BITS(5), .FLUSH_CYCLES(FA), .STALL_CYCLES(SA), .CNT_BITS(CA)) dut_a (
        .clk(clk), .rst(rst),
        .id_rs1(ia.rs1), .id_rs2(ia.rs2), .id_uses_rs2(ia.uses),
        .ex_rd(ia.rd), .ex_mem_read(ia.mr), .branch_taken(ia.br),
        .pc_write(a_pc), .if_id_write(a_ifid), .if_id_flush_sel(a_ifsel),
        .id_ex_flush_sel(a_idsel), .busy(a_busy),
        .flush_count(a_fc), .stall_count(a_sc)
    );

    hazard_flush_ctrl #(.REG_BITS(5), .FLUSH_CYCLES(FB), .STALL_CYCLES(SB), .CNT_BITS(CB)) dut_b (
        .clk(clk), .rst(rst),
        .id_rs1(ib.rs1), .id_rs2(ib.rs2), .id_uses_rs2(ib.uses),
        .ex_rd(ib.rd), .ex_mem_read(ib.mr), .branch_taken(ib.br),
        .pc_write(b_pc), .if_id_write(b_ifid), .if_id_flush_sel(b_ifsel),
        .id_ex_flush_sel(b_idsel), .busy(b_busy),
        .flush_count(b_fc), .stall_count(b_sc)
    );

    assign oa = {a_pc, a_ifid, a_ifsel, a_idsel, a_busy};
    assign ob = {b_pc, b_ifid, b_ifsel, b_idsel, b_busy};

    function automatic in_t mkin(int rs1, int rs2, int uses, int rd, int mr, int br);
        in_t r;
        r.rs1  = 5'(rs1);
        r.rs2  = 5'(rs2);
        r.uses = 1'(uses);
        r.rd   = 5'(rd);
        r.mr   = 1'(mr);
        r.br   = 1'(br);
        return r;
    endfunction

    // Expected counter reading: saturated event count, or 0 when counters are not built.
    function automatic int cexp(int v, int bits);
        int mx = (1 << bits) - 1;
        int r  = (v > mx) ? mx : v;
`ifdef HAZARD_PERF_CNT_EN
        return r;
`else
        return r * 0;
`endif
    endfunction

    function automatic bit haz_f(in_t i);
        return i.mr && (i.rd != 0) && ((i.rd == i.rs1) || (i.uses && (i.rd == i.rs2)));
    endfunction

    // Reference model: remaining flush / stall cycles beyond the triggering cycle.
    function automatic out_t model_out(int k, in_t i);
        out_t o;
        o = 5'b11000;
        o[0] = (m_fl[k] > 0) || (m_st[k] > 0);
        if (m_fl[k] > 0 || i.br) begin
            o[2] = 1'b1;
            o[1] = 1'b1;
        end else if (m_st[k] > 0 || haz_f(i)) begin
            o[4] = 1'b0;
            o[3] = 1'b0;
            o[1] = 1'b1;
        end
        return o;
    endfunction

    task automatic model_step(int k, in_t i);
        int fcy = (k == 0) ? FA : FB;
        int scy = (k == 0) ? SA : SB;
        if (m_fl[k] > 0) begin
            m_fl[k]--;
        end else if (i.br) begin
            m_fl[k] = fcy - 1;
            m_st[k] = 0;
            m_fc[k]++;
        end else if (m_st[k] > 0) begin
            m_st[k]--;
        end else if (haz_f(i)) begin
            m_st[k] = scy - 1;
            m_sc[k]++;
        end
    endtask

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_fl[k] = 0; m_st[k] = 0; m_fc[k] = 0; m_sc[k] = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic drive_b(in_t i, out_t ex, string nm);
        ib = i;
        #1 chk(nm, int'(ob), int'(ex));
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[14];
    in_t  IDLE;

    initial begin
        IDLE = mkin(1, 2, 1, 3, 1, 0);
        tbl[0]  = '{IDLE,                    5'b11000, 0, 0};
        tbl[1]  = '{mkin(5, 2, 1, 5, 1, 0),  5'b00010, 0, 0};
        tbl[2]  = '{IDLE,                    5'b11000, 0, 1};
        tbl[3]  = '{mkin(0, 2, 1, 0, 1, 0),  5'b11000, 0, 1};
        tbl[4]  = '{mkin(1, 7, 0, 7, 1, 0),  5'b11000, 0, 1};
        tbl[5]  = '{mkin(1, 7, 1, 7, 1, 0),  5'b00010, 0, 1};
        tbl[6]  = '{IDLE,                    5'b11000, 0, 2};
        tbl[7]  = '{mkin(1, 2, 1, 3, 1, 1),  5'b11110, 0, 2};
        tbl[8]  = '{mkin(1, 2, 1, 3, 1, 1),  5'b11111, 1, 2};
        tbl[9]  = '{IDLE,                    5'b11000, 1, 2};
        tbl[10] = '{mkin(5, 2, 1, 5, 1, 1),  5'b11110, 1, 2};
        tbl[11] = '{mkin(5, 2, 1, 5, 1, 0),  5'b11111, 2, 2};
        tbl[12] = '{mkin(5, 2, 1, 5, 1, 0),  5'b00010, 2, 2};
        tbl[13] = '{IDLE,                    5'b11000, 2, 3};

        ia = IDLE;
        ib = IDLE;
        model_clear();
        #1;
        chk("reset_out_a", int'(oa), 5'b11000);
        chk("reset_out_b", int'(ob), 5'b11000);
        chk("reset_fc_a", int'(a_fc), 0);
        chk("reset_sc_a", int'(a_sc), 0);
        chk("reset_fc_b", int'(b_fc), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("release_out_a", int'(oa), 5'b11000);
        chk("release_out_b", int'(ob), 5'b11000);
        @(posedge clk);
        #1;

        for (int n = 0; n < 14; n++) begin
            ia = tbl[n].i;
            #1;
            chk($sformatf("tbl%0d_out", n), int'(oa), int'(tbl[n].o));
            chk($sformatf("tbl%0d_fc", n), int'(a_fc), cexp(tbl[n].fc, CA));
            chk($sformatf("tbl%0d_sc", n), int'(a_sc), cexp(tbl[n].sc, CA));
            @(posedge clk);
            #1;
        end

        // Branch arriving in the second stall cycle wins and opens a full-length flush.
        ia = IDLE;
        do_reset();
        drive_b(mkin(4, 2, 1, 4, 1, 0), 5'b00010, "prio_stall1");
        drive_b(mkin(4, 2, 1, 4, 1, 1), 5'b11111, "prio_branch");
        drive_b(IDLE, 5'b11111, "prio_flush2");
        drive_b(IDLE, 5'b11111, "prio_flush3");
        drive_b(IDLE, 5'b11000, "prio_run");
        chk("prio_fc", int'(b_fc), cexp(1, CB));
        chk("prio_sc", int'(b_sc), cexp(1, CB));

        // Reset pulled in the middle of a stall drops straight back to the RUN decode.
        do_reset();
        drive_b(mkin(4, 2, 1, 4, 1, 0), 5'b00010, "rst_stall1");
        drive_b(IDLE, 5'b00011, "rst_stall2");
        rst = 1'b0;
        #1 chk("rst_mid_out", int'(ob), 5'b11000);
        chk("rst_mid_sc", int'(b_sc), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        drive_b(IDLE, 5'b11000, "rst_after");

        // 60 cycles of branch_taken with a 3-cycle flush: 20 counted events.
        do_reset();
        ib = mkin(1, 2, 1, 3, 0, 1);
        repeat (60) @(posedge clk);
        #1;
        chk("sat_fc", int'(b_fc), cexp(20, CB));
        chk("sat_sc", int'(b_sc), 0);
        ib = IDLE;
        @(posedge clk);
        #1;

        do_reset();
        for (int n = 0; n < 1500; n++) begin
            in_t ra, rb;
            ra = mkin($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                      $urandom_range(0, 3), $urandom_range(0, 1), ($urandom_range(0, 5) == 0));
            rb = mkin($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                      $urandom_range(0, 3), $urandom_range(0, 1), ($urandom_range(0, 7) == 0));
            ia = ra;
            ib = rb;
            #1;
            chk("rand_out_a", int'(oa), int'(model_out(0, ra)));
            chk("rand_out_b", int'(ob), int'(model_out(1, rb)));
            chk("rand_fc_a", int'(a_fc), cexp(m_fc[0], CA));
            chk("rand_sc_a", int'(a_sc), cexp(m_sc[0], CA));
            chk("rand_fc_b", int'(b_fc), cexp(m_fc[1], CB));
            chk("rand_sc_b", int'(b_sc), cexp(m_sc[1], CB));
            @(posedge clk);
            model_step(0, ra);
            model_step(1, rb);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
- Pipeline hazard and flush controller for the 5-stage RISC-V core.
- Sits directly upstream of the DynamicMux2x1 flush muxes that zero the IF/ID and ID/EX register inputs, and drives their selector lines.
- Also gates PC and IF/ID writes for load-use stalls.
- Sequences multi-cycle flushes after a taken branch or jump, and multi-cycle load-use stalls.

Parameters:
- REG_BITS, 5: width of register-file addresses.
- FLUSH_CYCLES, 2: cycles the IF/ID and ID/EX flush selectors stay high after a taken branch is resolved in EX. Legal range 1..15.
- STALL_CYCLES, 1: bubble cycles inserted per load-use hazard. Legal range 1..15.
- CNT_BITS, 16: width of the performance counters.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- id_rs1  input  REG_BITS  rs1 address of the instruction in ID.
- id_rs2  input  REG_BITS  rs2 address of the instruction in ID.
- id_uses_rs2  input  1  the ID instruction reads rs2.
- ex_rd  input  REG_BITS  destination register of the instruction in EX.
- ex_mem_read  input  1  the EX instruction is a load.
- branch_taken  input  1  the EX-stage branch or jump resolved taken this cycle.
- pc_write  output  1  PC write enable.
- if_id_write  output  1  IF/ID register write enable.
- if_id_flush_sel  output  1  selector of the IF/ID flush mux (1 = zero/NOP).
- id_ex_flush_sel  output  1  selector of the ID/EX flush mux (1 = bubble).
- busy  output  1  state is not RUN.
- flush_count  output  CNT_BITS  taken-branch flush events; see Optional Feature.
- stall_count  output  CNT_BITS  load-use stall events; see Optional Feature.

Behaviour:
- Control outputs are combinational decodes of state and inputs (zero latency), because the flush muxes sit in the same cycle.
- State and counters are registers.
- Reset (rst=0): state=RUN, cnt=0, flush_count=0, stall_count=0, busy=0. Outputs follow the RUN decode of the current inputs.
- Hazard definition: haz = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2))). A write to x0 never stalls.
- Defaults in all states: pc_write=1, if_id_write=1, both flush selectors=0.
- RUN, branch_taken=1 (priority over haz):
  - if_id_flush_sel=1 and id_ex_flush_sel=1 this cycle.
  - If FLUSH_CYCLES>1: next state FLUSH, cnt=FLUSH_CYCLES-1. Otherwise stay in RUN.
  - flush_count increments.
- RUN, haz=1 and branch_taken=0:
  - pc_write=0, if_id_write=0, id_ex_flush_sel=1 this cycle.
  - If STALL_CYCLES>1: next state STALL, cnt=STALL_CYCLES-1. Otherwise stay in RUN.
  - stall_count increments.
- FLUSH:
  - Both flush selectors=1, pc_write=1.
  - cnt decrements; when cnt==1, next state RUN.
  - branch_taken in FLUSH is ignored: no reload, no count, because the flushed instruction cannot branch.
- STALL:
  - pc_write=0, if_id_write=0, id_ex_flush_sel=1.
  - cnt decrements; when cnt==1, next state RUN.
  - branch_taken in STALL aborts the stall and is handled exactly as branch_taken in RUN, including the FLUSH entry and the flush_count increment.
  - haz in STALL does not extend the stall or increment stall_count.
- busy=1 in FLUSH and STALL.
- Counters saturate at all-ones and never wrap.
- rst asserted mid-FLUSH or mid-STALL: immediately state=RUN and cnt=0. Outputs revert to the RUN decode asynchronously.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: flush_count and stall_count are implemented as described above.
- Undefined: no counter registers; both ports are driven constant 0. Control behaviour is unchanged.

Test Plan:
- Reset: rst=0 with branch_taken=0 and no hazard -> pc_write=1, if_id_write=1, both selectors=0, busy=0, counters=0. Release rst; outputs are unchanged.
- Load-use, STALL_CYCLES=1: ex_mem_read=1, ex_rd=5, id_rs1=5 -> one cycle with pc_write=0, if_id_write=0, id_ex_flush_sel=1; stall_count=1. Same stimulus with ex_rd=0 -> no stall.
- rs2 gating: ex_rd=7, id_rs2=7, id_uses_rs2=0 -> no stall. Set id_uses_rs2=1 -> stall.
- Branch flush, FLUSH_CYCLES=2: branch_taken pulse -> both selectors=1 for exactly 2 cycles, busy=1 in the second cycle, flush_count=1. A second branch_taken in that second cycle -> ignored, flush_count stays 1.
- Priority, STALL_CYCLES=3: hazard starts a stall; branch_taken asserted in stall cycle 2 -> pc_write=1 that cycle, both selectors=1, state FLUSH. Total flush length is FLUSH_CYCLES; stall_count=1, flush_count=1.
- Saturation with HAZARD_PERF_CNT_EN defined and CNT_BITS=4: 20 branch events -> flush_count=15. With the macro undefined -> both counter ports read 0.
